// File: rtl/alu_decoder.sv
// RV32I decode stage: turns instruction words into ALU control and buffers them in a 2-entry FIFO.
// Optional performance counters are built when ALU_DEC_PERF_CNT_EN is defined.
package types;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_SLL = 4'd2,
        ALU_XOR = 4'd3,
        ALU_SRL = 4'd4,
        ALU_SRA = 4'd5,
        ALU_OR  = 4'd6,
        ALU_AND = 4'd7
    } alu_op_t;

    typedef struct packed {
        alu_op_t     alu_op;
        logic [31:0] imm;
        logic        use_imm;
        logic        a_sel_pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        illegal;
    } dec_entry_t;
endpackage

module alu_decoder
    import types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alu_op,
    output logic [31:0] out_imm,
    output logic        out_use_imm,
    output logic        out_a_sel_pc,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_pc,
    output logic        out_illegal,
    output logic [31:0] out_dec_cnt,
    output logic [31:0] out_ill_cnt
);

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_in_ready;
    logic        r_out_valid;
    dec_entry_t  r_head;
    dec_entry_t  r_tail;
    dec_entry_t  w_entry;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_sh;
    logic            w_legal;

    logic w_push;
    logic w_pop;
    logic w_ld_head_in;
    logic w_ld_head_tail;
    logic w_ld_tail_in;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_u  = {in_instr[31:12], 12'b0};
    assign w_imm_sh = {27'b0, in_instr[24:20]};

    // Combinational decode of the incoming word; illegal encodings collapse to a neutral ADD.
    always_comb begin
        w_entry          = '0;
        w_entry.alu_op   = ALU_ADD;
        w_entry.rs1      = in_instr[19:15];
        w_entry.rs2      = in_instr[24:20];
        w_entry.rd       = in_instr[11:7];
        w_entry.pc       = in_pc;
        w_legal          = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                if (w_funct7 == F7_ZERO) begin
                    w_legal = 1'b1;
                    case (w_funct3)
                        3'b000:  w_entry.alu_op = ALU_ADD;
                        3'b001:  w_entry.alu_op = ALU_SLL;
                        3'b100:  w_entry.alu_op = ALU_XOR;
                        3'b101:  w_entry.alu_op = ALU_SRL;
                        3'b110:  w_entry.alu_op = ALU_OR;
                        3'b111:  w_entry.alu_op = ALU_AND;
                        default: w_legal = 1'b0;
                    endcase
                end else if (w_funct7 == F7_ALT) begin
                    if (w_funct3 == 3'b000) begin
                        w_entry.alu_op = ALU_SUB;
                        w_legal        = 1'b1;
                    end else if (w_funct3 == 3'b101) begin
                        w_entry.alu_op = ALU_SRA;
                        w_legal        = 1'b1;
                    end
                end
            end
            OPC_OP_IMM: begin
                w_entry.use_imm = 1'b1;
                w_entry.imm     = w_imm_i;
                w_legal         = 1'b1;
                case (w_funct3)
                    3'b000: w_entry.alu_op = ALU_ADD;
                    3'b100: w_entry.alu_op = ALU_XOR;
                    3'b110: w_entry.alu_op = ALU_OR;
                    3'b111: w_entry.alu_op = ALU_AND;
                    3'b001: begin
                        w_entry.alu_op = ALU_SLL;
                        w_entry.imm    = w_imm_sh;
                        w_legal        = (w_funct7 == F7_ZERO);
                    end
                    3'b101: begin
                        w_entry.alu_op = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        w_entry.imm    = w_imm_sh;
                        w_legal        = (w_funct7 == F7_ZERO) || (w_funct7 == F7_ALT);
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                w_legal         = 1'b1;
                w_entry.use_imm = 1'b1;
                w_entry.imm     = w_imm_u;
                w_entry.rs1     = 5'd0;
            end
            OPC_AUIPC: begin
                w_legal          = 1'b1;
                w_entry.use_imm  = 1'b1;
                w_entry.a_sel_pc = 1'b1;
                w_entry.imm      = w_imm_u;
            end
            OPC_LOAD: begin
                w_legal         = 1'b1;
                w_entry.use_imm = 1'b1;
                w_entry.imm     = w_imm_i;
            end
            OPC_STORE: begin
                w_legal         = 1'b1;
                w_entry.use_imm = 1'b1;
                w_entry.imm     = w_imm_s;
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_entry.alu_op   = ALU_ADD;
            w_entry.imm      = '0;
            w_entry.use_imm  = 1'b0;
            w_entry.a_sel_pc = 1'b0;
            w_entry.rs1      = in_instr[19:15];
        end
        w_entry.illegal = ~w_legal;
    end

    assign w_push = in_valid & r_in_ready & ~flush;
    assign w_pop  = r_out_valid & out_ready & ~flush;

    // Buffer state register; handshake flags are registered copies of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Next-state and load-enable logic; flush overrides everything.
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_head_in   = 1'b0;
        w_ld_head_tail = 1'b0;
        w_ld_tail_in   = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_ld_head_in = 1'b1;
                        w_state_nxt  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_ld_head_in = 1'b1;
                    end else if (w_push) begin
                        w_ld_tail_in = 1'b1;
                        w_state_nxt  = ST_FULL;
                    end else if (w_pop) begin
                        w_state_nxt  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_ld_head_tail = 1'b1;
                        w_state_nxt    = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_ld_head_in) begin
                r_head <= w_entry;
            end else if (w_ld_head_tail) begin
                r_head <= r_tail;
            end
            if (w_ld_tail_in) begin
                r_tail <= w_entry;
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_alu_op   = r_head.alu_op;
    assign out_imm      = r_head.imm;
    assign out_use_imm  = r_head.use_imm;
    assign out_a_sel_pc = r_head.a_sel_pc;
    assign out_rs1      = r_head.rs1;
    assign out_rs2      = r_head.rs2;
    assign out_rd       = r_head.rd;
    assign out_pc       = r_head.pc;
    assign out_illegal  = r_head.illegal;

`ifdef ALU_DEC_PERF_CNT_EN
    logic [31:0] r_dec_cnt;
    logic [31:0] r_ill_cnt;

    // Pop counters survive flush and wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_cnt <= '0;
            r_ill_cnt <= '0;
        end else if (w_pop) begin
            r_dec_cnt <= r_dec_cnt + 32'd1;
            if (r_head.illegal) begin
                r_ill_cnt <= r_ill_cnt + 32'd1;
            end
        end
    end

    assign out_dec_cnt = r_dec_cnt;
    assign out_ill_cnt = r_ill_cnt;
`else
    assign out_dec_cnt = '0;
    assign out_ill_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: directed cases plus random traffic against a queue-based model.
module tb_alu_decoder;
    import types::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_op;
    logic [31:0] out_imm;
    logic        out_use_imm;
    logic        out_a_sel_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_pc;
    logic        out_illegal;
    logic [31:0] out_dec_cnt;
    logic [31:0] out_ill_cnt;

    alu_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_alu_op   (out_alu_op),
        .out_imm      (out_imm),
        .out_use_imm  (out_use_imm),
        .out_a_sel_pc (out_a_sel_pc),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_pc       (out_pc),
        .out_illegal  (out_illegal),
        .out_dec_cnt  (out_dec_cnt),
        .out_ill_cnt  (out_ill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  alu_op;
        logic [31:0] imm;
        logic        use_imm;
        logic        a_sel_pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        illegal;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_dec_cnt = 0;
    logic [31:0] m_ill_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference decode from the instruction-set rules, table-driven on funct3.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic [3:0]  base_op[8];
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] simm;
        bit          ok;
        base_op[0] = ALU_ADD; base_op[1] = ALU_SLL; base_op[2] = 4'hF; base_op[3] = 4'hF;
        base_op[4] = ALU_XOR; base_op[5] = ALU_SRL; base_op[6] = ALU_OR; base_op[7] = ALU_AND;
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        simm = 32'($signed(ins) >>> 20);
        e.alu_op = ALU_ADD; e.imm = 0; e.use_imm = 0; e.a_sel_pc = 0;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.pc = pc;
        ok = 0;
        if (opc == 7'h33) begin
            if (f7 == 7'h00 && base_op[f3] != 4'hF) begin
                ok = 1; e.alu_op = base_op[f3];
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                ok = 1; e.alu_op = ALU_SUB;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                ok = 1; e.alu_op = ALU_SRA;
            end
        end else if (opc == 7'h13) begin
            e.use_imm = 1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                e.imm = 32'(ins[24:20]);
                if (f7 == 7'h00) begin
                    ok = 1; e.alu_op = base_op[f3];
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    ok = 1; e.alu_op = ALU_SRA;
                end
            end else if (base_op[f3] != 4'hF) begin
                ok = 1; e.alu_op = base_op[f3]; e.imm = simm;
            end
        end else if (opc == 7'h37) begin
            ok = 1; e.use_imm = 1; e.imm = ins & 32'hFFFF_F000; e.rs1 = 0;
        end else if (opc == 7'h17) begin
            ok = 1; e.use_imm = 1; e.a_sel_pc = 1; e.imm = ins & 32'hFFFF_F000;
        end else if (opc == 7'h03) begin
            ok = 1; e.use_imm = 1; e.imm = simm;
        end else if (opc == 7'h23) begin
            ok = 1; e.use_imm = 1; e.imm = (simm & 32'hFFFF_FFE0) | 32'(ins[11:7]);
        end
        if (!ok) begin
            e.alu_op = ALU_ADD; e.imm = 0; e.use_imm = 0; e.a_sel_pc = 0; e.rs1 = ins[19:15];
        end
        e.illegal = !ok;
        return e;
    endfunction

    task automatic check_all();
        exp_t h;
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            h = q[0];
            chk("alu_op", 32'(out_alu_op), 32'(h.alu_op));
            chk("imm", out_imm, h.imm);
            chk("use_imm", 32'(out_use_imm), 32'(h.use_imm));
            chk("a_sel_pc", 32'(out_a_sel_pc), 32'(h.a_sel_pc));
            chk("rs1", 32'(out_rs1), 32'(h.rs1));
            chk("rs2", 32'(out_rs2), 32'(h.rs2));
            chk("rd", 32'(out_rd), 32'(h.rd));
            chk("pc", out_pc, h.pc);
            chk("illegal", 32'(out_illegal), 32'(h.illegal));
        end
`ifdef ALU_DEC_PERF_CNT_EN
        chk("dec_cnt", out_dec_cnt, m_dec_cnt);
        chk("ill_cnt", out_ill_cnt, m_ill_cnt);
`else
        chk("dec_cnt", out_dec_cnt, 32'd0);
        chk("ill_cnt", out_ill_cnt, 32'd0);
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, then check just after it.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        bit   m_rdy;
        bit   m_vld;
        exp_t popped;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        m_rdy = (q.size() < 2);
        m_vld = (q.size() > 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (m_vld && ordy) begin
                popped = q.pop_front();
                m_dec_cnt++;
                if (popped.illegal) m_ill_cnt++;
            end
            if (v && m_rdy) q.push_back(ref_decode(ins, pc));
        end
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        int          r;
        w = $urandom;
        k = $urandom_range(0, 9);
        r = $urandom_range(0, 3);
        case (k)
            0, 1:    w[6:0] = 7'h33;
            2, 3:    w[6:0] = 7'h13;
            4:       w[6:0] = 7'h37;
            5:       w[6:0] = 7'h17;
            6:       w[6:0] = 7'h03;
            7:       w[6:0] = 7'h23;
            default: ;
        endcase
        if (k <= 3) begin
            if (r <= 1)      w[31:25] = 7'h00;
            else if (r == 2) w[31:25] = 7'h20;
        end
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_alu_op", 32'(out_alu_op), 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        chk("rst_dec_cnt", out_dec_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        cycle(1, 32'h002081B3, 32'h0, 1, 0);
        chk("add_op", 32'(out_alu_op), 32'(ALU_ADD));
        chk("add_rs1", 32'(out_rs1), 32'd1);
        chk("add_rs2", 32'(out_rs2), 32'd2);
        chk("add_rd", 32'(out_rd), 32'd3);
        chk("add_use_imm", 32'(out_use_imm), 32'd0);
        cycle(1, 32'h4020D1B3, 32'h4, 1, 0);
        chk("sra_op", 32'(out_alu_op), 32'(ALU_SRA));
        cycle(1, 32'hFFF0C093, 32'h8, 1, 0);
        chk("xori_op", 32'(out_alu_op), 32'(ALU_XOR));
        chk("xori_imm", out_imm, 32'hFFFF_FFFF);
        cycle(1, 32'h4050D113, 32'hC, 1, 0);
        chk("srai_op", 32'(out_alu_op), 32'(ALU_SRA));
        chk("srai_imm", out_imm, 32'd5);
        chk("srai_use_imm", 32'(out_use_imm), 32'd1);
        cycle(1, 32'h12345097, 32'h100, 1, 0);
        chk("auipc_asel", 32'(out_a_sel_pc), 32'd1);
        chk("auipc_imm", out_imm, 32'h1234_5000);
        chk("auipc_pc", out_pc, 32'h100);
        cycle(1, 32'h0020A1B3, 32'h104, 1, 0);
        chk("slt_illegal", 32'(out_illegal), 32'd1);
        chk("slt_imm", out_imm, 32'd0);
        cycle(1, 32'hFFFFFFFF, 32'h108, 1, 0);
        chk("ffff_illegal", 32'(out_illegal), 32'd1);
        chk("ffff_op", 32'(out_alu_op), 32'(ALU_ADD));
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Backpressure: third push held until a pop, then order preserved.
        cycle(1, 32'h00500093, 32'h200, 0, 0);
        cycle(1, 32'h00600113, 32'h204, 0, 0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cycle(1, 32'h00700193, 32'h208, 0, 0);
        chk("held_head_pc", out_pc, 32'h200);
        cycle(1, 32'h00700193, 32'h208, 1, 0);
        cycle(1, 32'h00700193, 32'h208, 0, 0);
        chk("order_head_pc", out_pc, 32'h204);
        cycle(1, 32'h00800213, 32'h20C, 0, 1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Asynchronous reset while full.
        cycle(1, 32'h00100093, 32'h300, 0, 0);
        cycle(1, 32'h00200113, 32'h304, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_dec_cnt = 0;
        m_ill_cnt = 0;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_pc", out_pc, 32'd0);
        chk("arst_imm", out_imm, 32'd0);
        chk("arst_rd", 32'(out_rd), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 32'h0, 32'h0, 0, 0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
